// File: rtl/synth_syx_pkg.sv
// Shared definitions for the synth-parameter SysEx parser: parser states,
// MIDI framing constants and a byte classifier used by the FSM.
package synth_syx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ID   = 3'd1,
        ST_CHAN = 3'd2,
        ST_BANK = 3'd3,
        ST_ADDR = 3'd4,
        ST_DATA = 3'd5,
        ST_SKIP = 3'd6
    } syx_state_t;

    typedef enum logic [2:0] {
        BC_DATA   = 3'd0,
        BC_START  = 3'd1,
        BC_END    = 3'd2,
        BC_RT     = 3'd3,
        BC_STATUS = 3'd4
    } syx_byte_class_t;

    localparam logic [7:0] SYX_START  = 8'hF0;
    localparam logic [7:0] SYX_END    = 8'hF7;
    localparam logic [7:0] SYX_RT_MIN = 8'hF8;
    localparam int         NUM_BANKS  = 6;

    // Realtime bytes are checked before F0/F7 so they never disturb framing
    function automatic syx_byte_class_t syx_classify(input logic [7:0] b);
        syx_byte_class_t c;
        if (b[7] == 1'b0) begin
            c = BC_DATA;
        end else if (b >= SYX_RT_MIN) begin
            c = BC_RT;
        end else if (b == SYX_START) begin
            c = BC_START;
        end else if (b == SYX_END) begin
            c = BC_END;
        end else begin
            c = BC_STATUS;
        end
        return c;
    endfunction

endpackage

// File: rtl/syx_param_parser.sv
// SysEx parameter parser: turns F0 ID CHAN BANK ADDR DATA.. F7 into bank/address/data
// write strobes with a holdoff back-pressure counter. Optional macro: SYX_AUTOINC_EN.
module syx_param_parser
    import synth_syx_pkg::*;
#(
    parameter logic [6:0] MANUF_ID = 7'h7D,
    parameter int         HOLDOFF  = 6
) (
    input  logic       reg_clk,
    input  logic       reset_reg_N,
    input  logic [7:0] midi_byte,
    input  logic       midi_valid,
    output logic       midi_ready,
    input  logic [3:0] dev_ch,
    output logic [2:0] bank_adr,
    output logic [6:0] param_adr,
    output logic [7:0] out_data,
    output logic       data_ready,
    output logic       syx_active,
    output logic       syx_err
);

    syx_state_t      r_state;
    syx_state_t      w_state_nxt;
    syx_byte_class_t w_cls;
    logic            w_accept;
    logic            w_err_nxt;
    logic            w_strobe;
    logic            w_lat_bank;
    logic            w_lat_adr;

    logic [3:0]      r_hold_cnt;
    logic [2:0]      r_shadow_bank;
    logic [6:0]      r_shadow_adr;
    logic [2:0]      r_bank_adr;
    logic [6:0]      r_param_adr;
    logic [7:0]      r_out_data;
    logic            r_data_ready;
    logic            r_syx_active;
    logic            r_syx_err;

    assign w_accept   = midi_valid && midi_ready;
    assign w_cls      = syx_classify(midi_byte);
    assign midi_ready = (r_hold_cnt == 4'd0);

    assign bank_adr   = r_bank_adr;
    assign param_adr  = r_param_adr;
    assign out_data   = r_out_data;
    assign data_ready = r_data_ready;
    assign syx_active = r_syx_active;
    assign syx_err    = r_syx_err;

    // Next-state, error and latch-enable decode for the byte accepted this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_strobe    = 1'b0;
        w_lat_bank  = 1'b0;
        w_lat_adr   = 1'b0;
        if (w_accept) begin
            case (w_cls)
                BC_RT: begin
                    w_state_nxt = r_state;
                end
                BC_START: begin
                    w_state_nxt = ST_ID;
                    w_err_nxt   = (r_state != ST_IDLE) && (r_state != ST_SKIP);
                end
                BC_END: begin
                    w_state_nxt = ST_IDLE;
                end
                BC_STATUS: begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = (r_state != ST_IDLE);
                end
                BC_DATA: begin
                    case (r_state)
                        ST_ID: begin
                            if (midi_byte[6:0] == MANUF_ID) begin
                                w_state_nxt = ST_CHAN;
                            end else begin
                                w_state_nxt = ST_SKIP;
                                w_err_nxt   = 1'b1;
                            end
                        end
                        ST_CHAN: begin
                            if ((midi_byte[6:4] == 3'd0) && (midi_byte[3:0] == dev_ch)) begin
                                w_state_nxt = ST_BANK;
                            end else begin
                                w_state_nxt = ST_SKIP;
                                w_err_nxt   = 1'b1;
                            end
                        end
                        ST_BANK: begin
                            if (midi_byte[6:0] < 7'(NUM_BANKS)) begin
                                w_state_nxt = ST_ADDR;
                                w_lat_bank  = 1'b1;
                            end else begin
                                w_state_nxt = ST_SKIP;
                                w_err_nxt   = 1'b1;
                            end
                        end
                        ST_ADDR: begin
                            w_state_nxt = ST_DATA;
                            w_lat_adr   = 1'b1;
                        end
                        ST_DATA: begin
                            w_strobe = 1'b1;
`ifdef SYX_AUTOINC_EN
                            w_state_nxt = ST_DATA;
`else
                            w_state_nxt = ST_SKIP;
`endif
                        end
                        ST_IDLE, ST_SKIP: begin
                            w_state_nxt = r_state;
                        end
                        default: begin
                            w_state_nxt = ST_IDLE;
                        end
                    endcase
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Parser state plus the status outputs that track it
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_state      <= ST_IDLE;
            r_syx_active <= 1'b0;
            r_syx_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_syx_active <= (w_state_nxt != ST_IDLE);
            r_syx_err    <= w_err_nxt;
        end
    end

    // Shadow bank/address captured from the header; address may advance per strobe
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_shadow_bank <= 3'd0;
            r_shadow_adr  <= 7'd0;
        end else begin
            if (w_lat_bank) begin
                r_shadow_bank <= midi_byte[2:0];
            end
            if (w_lat_adr) begin
                r_shadow_adr <= midi_byte[6:0];
            end
`ifdef SYX_AUTOINC_EN
            else if (w_strobe) begin
                r_shadow_adr <= r_shadow_adr + 7'd1;
            end
`endif
        end
    end

    // Decoder-facing write port: values held between strobes
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_bank_adr   <= 3'd0;
            r_param_adr  <= 7'd0;
            r_out_data   <= 8'd0;
            r_data_ready <= 1'b0;
        end else begin
            r_data_ready <= w_strobe;
            if (w_strobe) begin
                r_bank_adr  <= r_shadow_bank;
                r_param_adr <= r_shadow_adr;
                r_out_data  <= {1'b0, midi_byte[6:0]};
            end
        end
    end

    // Holdoff counter: a strobe can only occur while it is zero, so loading never collides
    always_ff @(posedge reg_clk or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            r_hold_cnt <= 4'd0;
        end else if (w_strobe) begin
            r_hold_cnt <= 4'(HOLDOFF);
        end else if (r_hold_cnt != 4'd0) begin
            r_hold_cnt <= r_hold_cnt - 4'd1;
        end else begin
            r_hold_cnt <= r_hold_cnt;
        end
    end

endmodule
